// File: rtl/dcache_meta_array.sv
// Data-cache metadata array: 64 sets x 8 ways of {coh_state, tag}. After reset, an INIT sweep zeroes every set, then one write and one read are accepted per cycle.
// Optional macro DCACHE_META_BYPASS_EN: a read to the set being written in the same cycle returns the new entry for each way being written.
module dcache_meta_array (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_write_valid,
    output logic         io_write_ready,
    input  logic [5:0]   io_write_bits_idx,
    input  logic [7:0]   io_write_bits_way_en,
    input  logic [1:0]   io_write_bits_data_coh_state,
    input  logic [19:0]  io_write_bits_data_tag,
    input  logic         io_read_valid,
    output logic         io_read_ready,
    input  logic [5:0]   io_read_bits_idx,
    input  logic [7:0]   io_read_bits_way_en,
    output logic         io_resp_valid,
    output logic [175:0] io_resp_data,
    output logic         io_init_done
);
    localparam int NSETS = 64;
    localparam int NWAYS = 8;
    localparam int EW    = 22;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e         state_q, state_d;
    logic [5:0]     rst_cnt_q, rst_cnt_d;
    logic           in_init;
    logic           wr_fire, rd_fire;
    logic           mem_we;
    logic [5:0]     mem_widx;
    logic [7:0]     mem_wmask;
    logic [EW-1:0]  mem_wdata;
    logic [EW-1:0]  wr_entry;
    logic [EW-1:0]  mem_q [NSETS][NWAYS];
    logic [175:0]   rd_data_d;
    logic           resp_valid_q;
    logic [175:0]   resp_data_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // NOTE: each combinational block assigns defaults first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && rst_cnt_q == 6'd63) state_d = ST_READY;
    end

    always_comb begin
        in_init        = (state_q == ST_INIT);
        io_write_ready = (state_q == ST_READY);
        io_read_ready  = (state_q == ST_READY);
        io_init_done   = (state_q == ST_READY);
    end

    assign rst_cnt_d = in_init ? rst_cnt_q + 6'd1 : rst_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) rst_cnt_q <= '0;
        else       rst_cnt_q <= rst_cnt_d;
    end

    assign wr_fire  = io_write_valid & io_write_ready;
    assign rd_fire  = io_read_valid & io_read_ready;
    assign wr_entry = {io_write_bits_data_coh_state, io_write_bits_data_tag};

    // The INIT sweep shares the write port: all ways of set rst_cnt are cleared.
    assign mem_we    = in_init | wr_fire;
    assign mem_widx  = in_init ? rst_cnt_q : io_write_bits_idx;
    assign mem_wmask = in_init ? 8'hFF : io_write_bits_way_en;
    assign mem_wdata = in_init ? '0 : wr_entry;

    // NOTE: storage has no reset; the INIT sweep clears it, and leaving it out of reset lets it map to RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (mem_wmask[w]) mem_q[mem_widx][w] <= mem_wdata;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (io_read_bits_way_en[w]) begin
`ifdef DCACHE_META_BYPASS_EN
                if (wr_fire && io_write_bits_idx == io_read_bits_idx && io_write_bits_way_en[w])
                    rd_data_d[w*EW +: EW] = wr_entry;
                else
                    rd_data_d[w*EW +: EW] = mem_q[io_read_bits_idx][w];
`else
                rd_data_d[w*EW +: EW] = mem_q[io_read_bits_idx][w];
`endif
            end
        end
    end

    // The response data holds until the next read fires; the valid flag pulses for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= rd_fire;
            if (rd_fire) resp_data_q <= rd_data_d;
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_data  = resp_data_q;
endmodule

// File: tb/tb_dcache_meta_array.sv
// Randomized scoreboard bench for dcache_meta_array: the stimulus pushes expected responses, and a monitor pops them on io_resp_valid.
// Compile with DCACHE_META_BYPASS_EN to match an RTL built with the same-cycle bypass.
module tb_dcache_meta_array;
    logic         clock = 1'b0;
    logic         reset;
    logic         io_write_valid;
    logic         io_write_ready;
    logic [5:0]   io_write_bits_idx;
    logic [7:0]   io_write_bits_way_en;
    logic [1:0]   io_write_bits_data_coh_state;
    logic [19:0]  io_write_bits_data_tag;
    logic         io_read_valid;
    logic         io_read_ready;
    logic [5:0]   io_read_bits_idx;
    logic [7:0]   io_read_bits_way_en;
    logic         io_resp_valid;
    logic [175:0] io_resp_data;
    logic         io_init_done;

    dcache_meta_array dut (
        .clock                        (clock),
        .reset                        (reset),
        .io_write_valid               (io_write_valid),
        .io_write_ready               (io_write_ready),
        .io_write_bits_idx            (io_write_bits_idx),
        .io_write_bits_way_en         (io_write_bits_way_en),
        .io_write_bits_data_coh_state (io_write_bits_data_coh_state),
        .io_write_bits_data_tag       (io_write_bits_data_tag),
        .io_read_valid                (io_read_valid),
        .io_read_ready                (io_read_ready),
        .io_read_bits_idx             (io_read_bits_idx),
        .io_read_bits_way_en          (io_read_bits_way_en),
        .io_resp_valid                (io_resp_valid),
        .io_resp_data                 (io_resp_data),
        .io_init_done                 (io_init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [175:0] data;
        int           cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [21:0] model [64][8];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [175:0] got, input logic [175:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding read, in the cycle right after that read fired.
    always @(negedge clock) begin
        exp_t e;
        if (io_resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("resp_valid_spurious", 176'(io_resp_valid), 176'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_cycle", 176'(cyc), 176'(e.cyc));
                check("resp_data", io_resp_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_write_valid = 1'b0;
        io_read_valid  = 1'b0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) model[s][w] = '0;
    endtask

    // Drive one cycle of requests (the DUT must be READY) and record what the read must return.
    task automatic issue(input bit wv, input logic [5:0] widx, input logic [7:0] wway,
                         input logic [1:0] wcoh, input logic [19:0] wtag,
                         input bit rv, input logic [5:0] ridx, input logic [7:0] rway);
        exp_t        e;
        logic [21:0] v;
        io_write_valid               = wv;
        io_write_bits_idx            = widx;
        io_write_bits_way_en         = wway;
        io_write_bits_data_coh_state = wcoh;
        io_write_bits_data_tag       = wtag;
        io_read_valid                = rv;
        io_read_bits_idx             = ridx;
        io_read_bits_way_en          = rway;
        if (rv) begin
            e.data = '0;
            e.cyc  = cyc + 1;
            for (int w = 0; w < 8; w++) begin
                if (rway[w]) begin
                    v = model[ridx][w];
`ifdef DCACHE_META_BYPASS_EN
                    if (wv && widx == ridx && wway[w]) v = {wcoh, wtag};
`endif
                    e.data[w*22 +: 22] = v;
                end
            end
            sb_q.push_back(e);
        end
        if (wv) begin
            for (int w = 0; w < 8; w++)
                if (wway[w]) model[widx][w] = {wcoh, wtag};
        end
        step();
    endtask

    // Count the INIT cycles after reset release; init_done must rise after exactly 64 of them.
    task automatic wait_init(input string tag);
        int bad = 0;
        for (int i = 1; i <= 64; i++) begin
            if (io_init_done !== 1'b0 || io_write_ready !== 1'b0 || io_read_ready !== 1'b0) bad++;
            step();
        end
        check({tag, "_init_cycles_not_ready"}, 176'(bad), 176'd0);
        check({tag, "_init_done_at_65"}, 176'(io_init_done), 176'd1);
        check({tag, "_ready_at_65"}, 176'({io_write_ready, io_read_ready}), 176'd3);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        idle();
        io_write_bits_idx = '0;
        io_write_bits_way_en = '0;
        io_write_bits_data_coh_state = '0;
        io_write_bits_data_tag = '0;
        io_read_bits_idx = '0;
        io_read_bits_way_en = '0;
        model_clear();
        step();
        step();
        check("reset_resp_valid", 176'(io_resp_valid), 176'd0);
        check("reset_resp_data", io_resp_data, 176'd0);
        check("reset_ready_done", 176'({io_write_ready, io_read_ready, io_init_done}), 176'd0);

        // A read held during INIT is ignored; it fires on the first READY cycle and returns zeros.
        reset = 1'b0;
        io_read_valid = 1'b1;
        io_read_bits_idx = 6'd5;
        io_read_bits_way_en = 8'hFF;
        wait_init("first");
        e.data = '0;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        step();
        idle();

        // Single-way write, then full and masked reads of the same set.
        issue(1, 6'd10, 8'h04, 2'b11, 20'hABCDE, 0, 6'd0, 8'h00);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd10, 8'hFF);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd10, 8'h01);
        idle();
        step();
        check("resp_data_holds", io_resp_data, 176'd0);

        // A read and a write to the same set in the same cycle.
        issue(1, 6'd3, 8'h01, 2'b01, 20'h00001, 1, 6'd3, 8'hFF);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd3, 8'hFF);

        // A write with an all-zero way mask changes nothing.
        issue(1, 6'd10, 8'h00, 2'b10, 20'h55555, 0, 6'd0, 8'h00);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd10, 8'hFF);

        // Distinct writes, then back-to-back reads of sets 1, 2, 3.
        issue(1, 6'd1, 8'h81, 2'b01, 20'h11111, 0, 6'd0, 8'h00);
        issue(1, 6'd2, 8'h81, 2'b10, 20'h22222, 0, 6'd0, 8'h00);
        issue(1, 6'd3, 8'h81, 2'b11, 20'h33333, 0, 6'd0, 8'h00);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd1, 8'hFF);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd2, 8'hFF);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd3, 8'hFF);
        idle();
        step();

        // Random traffic; a narrow index range makes same-set collisions frequent.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] wi, ri;
            logic [7:0] ww, rw;
            bit         wv, rv;
            wv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 3) != 0);
            wi = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            ri = ($urandom_range(0, 2) == 0) ? wi : 6'($urandom_range(0, 7));
            ww = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rw = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            issue(wv, wi, ww, 2'($urandom), 20'($urandom), rv, ri, rw);
            if ($urandom_range(0, 9) == 0) begin
                idle();
                step();
            end
        end
        idle();
        step();
        check("queue_drained_random", 176'(sb_q.size()), 176'd0);

        // Reset on the cycle a read is presented drops the response; a second reset mid-sweep restarts INIT.
        io_read_valid = 1'b1;
        io_read_bits_idx = 6'd1;
        io_read_bits_way_en = 8'hFF;
        reset = 1'b1;
        step();
        check("reset_drops_resp", 176'(io_resp_valid), 176'd0);
        idle();
        step();
        reset = 1'b0;
        model_clear();
        repeat (30) step();
        check("midsweep_not_done", 176'(io_init_done), 176'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_init("restart");
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd1, 8'hFF);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd3, 8'hFF);
        issue(0, 6'd0, 8'h00, 2'b00, 20'h0, 1, 6'd10, 8'hFF);
        idle();
        repeat (3) step();
        check("queue_drained_final", 176'(sb_q.size()), 176'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
